// File: rtl/ball_motion_if.sv
// Ball motion control bus: frame/serve/paddle inputs and ball state outputs.
// master drives the inputs; slave is the ball motion sequencer.
interface ball_motion_if;
  logic        frame_tick;
  logic        serve_req;
  logic [11:0] left_paddle_row;
  logic [11:0] right_paddle_row;
  logic [11:0] ball_center_row;
  logic [11:0] ball_center_col;
  logic [1:0]  ball_direction;
  logic        ball_active;
  logic        paddle_hit;
  logic        score_left;
  logic        score_right;

  modport master (
    output frame_tick, serve_req,
    output left_paddle_row, right_paddle_row,
    input  ball_center_row, ball_center_col,
    input  ball_direction, ball_active,
    input  paddle_hit, score_left, score_right
  );

  modport slave (
    input  frame_tick, serve_req,
    input  left_paddle_row, right_paddle_row,
    output ball_center_row, ball_center_col,
    output ball_direction, ball_active,
    output paddle_hit, score_left, score_right
  );
endinterface

// File: rtl/ball_motion_ctrl.sv
// Ball serve/play/score sequencer; position moves only on frame_tick.
// Define BALL_SPEEDUP_EN to add one pixel of step per paddle hit, up to MAX_STEP.
module ball_motion_ctrl #(
  parameter int DISP_COLS        = 640,
  parameter int DISP_ROWS        = 480,
  parameter int BALL_WIDTH       = 6,
  parameter int BALL_HEIGHT      = 8,
  parameter int PADDLE_HEIGHT    = 48,
  parameter int LEFT_PADDLE_COL  = 16,
  parameter int RIGHT_PADDLE_COL = 624,
  parameter int STEP             = 2,
  parameter int SERVE_FRAMES     = 60,
  parameter int MAX_STEP         = 6
) (
  input logic          clk,
  input logic          rst_n,
  ball_motion_if.slave bus
);
  localparam int H  = BALL_HEIGHT / 2;
  localparam int W  = BALL_WIDTH / 2;
  localparam int CW = $clog2(SERVE_FRAMES + 1);
  localparam int SW = $clog2((MAX_STEP > STEP ? MAX_STEP : STEP) + 1);

  typedef logic signed [12:0] s13_t;

  localparam s13_t K_H    = s13_t'(H);
  localparam s13_t K_W    = s13_t'(W);
  localparam s13_t K_LIM  = s13_t'(PADDLE_HEIGHT / 2 + H);
  localparam s13_t K_RPC  = s13_t'(RIGHT_PADDLE_COL);
  localparam s13_t K_LPC  = s13_t'(LEFT_PADDLE_COL);
  localparam s13_t K_RMAX = s13_t'(DISP_ROWS - 1);
  localparam s13_t K_CMAX = s13_t'(DISP_COLS - 1);
  localparam s13_t K_ZERO = s13_t'(0);

  localparam logic [11:0]   ROW_C  = 12'(DISP_ROWS / 2);
  localparam logic [11:0]   COL_C  = 12'(DISP_COLS / 2);
  localparam logic [SW-1:0] STEP_I = SW'(STEP);
`ifdef BALL_SPEEDUP_EN
  localparam logic [SW-1:0] MAX_I  = SW'(MAX_STEP);
`endif

  typedef enum logic [1:0] {
    IDLE,
    SERVE,
    MOVING,
    SCORED
  } state_t;

  state_t        state_q, state_n;
  logic [11:0]   row_q, row_n;
  logic [11:0]   col_q, col_n;
  logic [1:0]    dir_q, dir_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [SW-1:0] step_q, step_n;
  logic          act_q, act_n;
  logic          hit_q, hit_n;
  logic          sl_q, sl_n;
  logic          sr_q, sr_n;

  s13_t r, c, s, ny, nx, dr, dl;
  logic ovl_r, ovl_l, cross_r, cross_l;

  always_comb begin
    state_n = state_q;
    row_n   = row_q;
    col_n   = col_q;
    dir_n   = dir_q;
    cnt_n   = cnt_q;
    step_n  = step_q;
    hit_n   = 1'b0;
    sl_n    = 1'b0;
    sr_n    = 1'b0;

    s  = s13_t'(step_q);
    r  = s13_t'(row_q);
    c  = s13_t'(col_q);
    ny = dir_q[0] ? r + s : r - s;
    nx = dir_q[1] ? c + s : c - s;
    dr = r - s13_t'(bus.right_paddle_row);
    dl = r - s13_t'(bus.left_paddle_row);
    ovl_r = (dr <= K_LIM) && (dr >= -K_LIM);
    ovl_l = (dl <= K_LIM) && (dl >= -K_LIM);
    // leading edge crosses the paddle plane during this update
    cross_r = dir_q[1] && (c + K_W < K_RPC) && (nx + K_W >= K_RPC);
    cross_l = !dir_q[1] && (c - K_W > K_LPC) && (nx - K_W <= K_LPC);

    unique case (state_q)
      IDLE: begin
        row_n = ROW_C;
        col_n = COL_C;
        if (bus.serve_req) begin
          state_n = SERVE;
          cnt_n   = CW'(SERVE_FRAMES);
        end
      end
      SERVE: begin
        if (bus.frame_tick) begin
          if (cnt_q == CW'(1)) begin
            state_n = MOVING;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_q - CW'(1);
          end
        end
      end
      MOVING: begin
        if (bus.frame_tick) begin
          if (dir_q[0] && (ny + K_H >= K_RMAX)) begin
            row_n    = 12'(DISP_ROWS - 1 - H);
            dir_n[0] = 1'b0;
          end else if (!dir_q[0] && (ny - K_H <= K_ZERO)) begin
            row_n    = 12'(H);
            dir_n[0] = 1'b1;
          end else begin
            row_n = ny[11:0];
          end

          if (cross_r && ovl_r) begin
            col_n    = 12'(RIGHT_PADDLE_COL - 1 - W);
            dir_n[1] = 1'b0;
            hit_n    = 1'b1;
          end else if (cross_l && ovl_l) begin
            col_n    = 12'(LEFT_PADDLE_COL + 1 + W);
            dir_n[1] = 1'b1;
            hit_n    = 1'b1;
          end else if (dir_q[1] && (nx + K_W >= K_CMAX)) begin
            sl_n    = 1'b1;
            state_n = SCORED;
            row_n   = ROW_C;
            col_n   = COL_C;
          end else if (!dir_q[1] && (nx - K_W <= K_ZERO)) begin
            sr_n    = 1'b1;
            state_n = SCORED;
            row_n   = ROW_C;
            col_n   = COL_C;
          end else begin
            col_n = nx[11:0];
          end
        end
      end
      SCORED: begin
        row_n   = ROW_C;
        col_n   = COL_C;
        step_n  = STEP_I;
        // serve toward the player who missed
        dir_n   = sl_q ? 2'b11 : 2'b01;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

`ifdef BALL_SPEEDUP_EN
    if (hit_n && (step_q < MAX_I)) step_n = step_q + SW'(1);
`endif

    act_n = (state_n == MOVING);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= ROW_C;
      col_q   <= COL_C;
      dir_q   <= 2'b11;
      cnt_q   <= '0;
      step_q  <= STEP_I;
      act_q   <= 1'b0;
      hit_q   <= 1'b0;
      sl_q    <= 1'b0;
      sr_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      row_q   <= row_n;
      col_q   <= col_n;
      dir_q   <= dir_n;
      cnt_q   <= cnt_n;
      step_q  <= step_n;
      act_q   <= act_n;
      hit_q   <= hit_n;
      sl_q    <= sl_n;
      sr_q    <= sr_n;
    end
  end

  assign bus.ball_center_row = row_q;
  assign bus.ball_center_col = col_q;
  assign bus.ball_direction  = dir_q;
  assign bus.ball_active     = act_q;
  assign bus.paddle_hit      = hit_q;
  assign bus.score_left      = sl_q;
  assign bus.score_right     = sr_q;
endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Bench for ball_motion_ctrl: directed scenarios then random play,
// every cycle compared against a behavioural model of the ball.
module tb_ball_motion_ctrl;
  localparam int DISP_COLS = 640;
  localparam int DISP_ROWS = 480;
  localparam int BW        = 6;
  localparam int BH        = 8;
  localparam int PH        = 48;
  localparam int LPC       = 16;
  localparam int RPC       = 624;
  localparam int STEP      = 2;
  localparam int SERVE_FR  = 60;
  localparam int MAX_STEP  = 6;
  localparam int H         = BH / 2;
  localparam int W         = BW / 2;
`ifdef BALL_SPEEDUP_EN
  localparam int T4_STEP = STEP + 1;
`else
  localparam int T4_STEP = STEP;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  ball_motion_if bus();

  ball_motion_ctrl #(
    .DISP_COLS(DISP_COLS), .DISP_ROWS(DISP_ROWS),
    .BALL_WIDTH(BW), .BALL_HEIGHT(BH),
    .PADDLE_HEIGHT(PH),
    .LEFT_PADDLE_COL(LPC), .RIGHT_PADDLE_COL(RPC),
    .STEP(STEP), .SERVE_FRAMES(SERVE_FR),
    .MAX_STEP(MAX_STEP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // model: ball position/heading plus game phase flags
  int m_row, m_col, m_dir, m_step, m_wait;
  bit m_idle, m_scored, m_hit, m_sl, m_sr;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(string ph);
    chk({ph, ".row"}, 32'(bus.ball_center_row), 32'(m_row));
    chk({ph, ".col"}, 32'(bus.ball_center_col), 32'(m_col));
    chk({ph, ".dir"}, 32'(bus.ball_direction), 32'(m_dir));
    chk({ph, ".active"}, 32'(bus.ball_active),
        32'(!m_idle && !m_scored && m_wait == 0));
    chk({ph, ".hit"}, 32'(bus.paddle_hit), 32'(m_hit));
    chk({ph, ".sl"}, 32'(bus.score_left), 32'(m_sl));
    chk({ph, ".sr"}, 32'(bus.score_right), 32'(m_sr));
  endtask

  task automatic model_reset();
    m_row = DISP_ROWS / 2;
    m_col = DISP_COLS / 2;
    m_dir = 3;
    m_step = STEP;
    m_wait = 0;
    m_idle = 1;
    m_scored = 0;
    m_hit = 0;
    m_sl = 0;
    m_sr = 0;
  endtask

  task automatic model_move(int lp, int rp);
    int nx, ny, nd;
    bit right, down, ovl_r, ovl_l;
    right = (m_dir & 2) != 0;
    down  = (m_dir & 1) != 0;
    nx = m_col + (right ? m_step : -m_step);
    ny = m_row + (down ? m_step : -m_step);
    nd = m_dir;
    ovl_r = (m_row - rp <= PH / 2 + H) && (rp - m_row <= PH / 2 + H);
    ovl_l = (m_row - lp <= PH / 2 + H) && (lp - m_row <= PH / 2 + H);
    if (down && ny + H >= DISP_ROWS - 1) begin
      ny = DISP_ROWS - 1 - H;
      nd = nd & 2;
    end else if (!down && ny - H <= 0) begin
      ny = H;
      nd = nd | 1;
    end
    if (right && m_col + W < RPC && nx + W >= RPC && ovl_r) begin
      nx = RPC - 1 - W;
      nd = nd ^ 2;
      m_hit = 1;
    end else if (!right && m_col - W > LPC && nx - W <= LPC && ovl_l) begin
      nx = LPC + 1 + W;
      nd = nd ^ 2;
      m_hit = 1;
    end else if (right && nx + W >= DISP_COLS - 1) begin
      m_sl = 1;
      m_scored = 1;
      nx = DISP_COLS / 2;
      ny = DISP_ROWS / 2;
    end else if (!right && nx - W <= 0) begin
      m_sr = 1;
      m_scored = 1;
      nx = DISP_COLS / 2;
      ny = DISP_ROWS / 2;
    end
`ifdef BALL_SPEEDUP_EN
    if (m_hit && m_step < MAX_STEP) m_step++;
`endif
    m_row = ny;
    m_col = nx;
    m_dir = nd;
  endtask

  task automatic model_clock(bit tick, bit serve, int lp, int rp);
    bit prev_sl;
    prev_sl = m_sl;
    m_hit = 0;
    m_sl = 0;
    m_sr = 0;
    if (m_scored) begin
      m_scored = 0;
      m_idle = 1;
      m_row = DISP_ROWS / 2;
      m_col = DISP_COLS / 2;
      m_dir = prev_sl ? 3 : 1;
      m_step = STEP;
    end else if (m_idle) begin
      m_row = DISP_ROWS / 2;
      m_col = DISP_COLS / 2;
      if (serve) begin
        m_idle = 0;
        m_wait = SERVE_FR;
      end
    end else if (m_wait > 0) begin
      if (tick) m_wait--;
    end else if (tick) begin
      model_move(lp, rp);
    end
  endtask

  task automatic step_cycle(bit tick, bit serve, int lp, int rp);
    bus.frame_tick = tick;
    bus.serve_req = serve;
    bus.left_paddle_row = 12'(lp);
    bus.right_paddle_row = 12'(rp);
    @(posedge clk);
    model_clock(tick, serve, lp, rp);
    #1;
    check_all("cyc");
    bus.frame_tick = 1'b0;
    bus.serve_req = 1'b0;
  endtask

  task automatic tick(int lp, int rp);
    step_cycle(1, 0, lp, rp);
    step_cycle(0, 0, lp, rp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("rst");
    rst_n = 1'b1;
  endtask

  task automatic serve_and_launch();
    step_cycle(0, 1, 40, 40);
    repeat (SERVE_FR) tick(40, 40);
  endtask

  int far_lp;
  bit seen;

  initial begin
    bus.frame_tick = 1'b0;
    bus.serve_req = 1'b0;
    bus.left_paddle_row = 12'd40;
    bus.right_paddle_row = 12'd40;

    // reset, then ticks with no serve keep the ball parked
    do_reset();
    repeat (10) tick(40, 40);
    chk("t1.row", 32'(bus.ball_center_row), 240);
    chk("t1.col", 32'(bus.ball_center_col), 320);
    chk("t1.dir", 32'(bus.ball_direction), 3);
    chk("t1.active", 32'(bus.ball_active), 0);

    // serve delay of exactly SERVE_FRAMES ticks
    step_cycle(0, 1, 40, 40);
    repeat (SERVE_FR - 1) tick(40, 40);
    chk("t2.active_early", 32'(bus.ball_active), 0);
    step_cycle(1, 0, 40, 40);
    chk("t2.active_rise", 32'(bus.ball_active), 1);
    step_cycle(0, 0, 40, 40);
    tick(40, 40);
    chk("t2.row", 32'(bus.ball_center_row), 242);
    chk("t2.col", 32'(bus.ball_center_col), 322);

    // bottom wall bounce
    for (int k = 0; k < 400 && m_row != 474; k++) tick(40, 40);
    chk("t3.pre_row", 32'(bus.ball_center_row), 474);
    step_cycle(1, 0, 40, 40);
    chk("t3.row", 32'(bus.ball_center_row), 475);
    chk("t3.dir", 32'(bus.ball_direction), 2);
    step_cycle(0, 0, 40, 40);
    tick(40, 40);
    chk("t3.row_up", 32'(bus.ball_center_row), 473);

    // right paddle bounce with paddle centered on the ball
    for (int k = 0; k < 200 && !(m_col == 620 && (m_dir & 2) != 0); k++)
      tick(40, m_row);
    chk("t4.pre_col", 32'(bus.ball_center_col), 620);
    step_cycle(1, 0, 40, m_row);
    chk("t4.col", 32'(bus.ball_center_col), 620);
    chk("t4.dir_left", 32'(bus.ball_direction[1]), 0);
    chk("t4.hit", 32'(bus.paddle_hit), 1);
    step_cycle(0, 0, 40, 40);
    chk("t4.hit_drop", 32'(bus.paddle_hit), 0);
    tick(40, 40);
    chk("t4.next_col", 32'(bus.ball_center_col), 620 - T4_STEP);

    // left miss: right player scores, next serve heads DOWN_LEFT
    seen = 0;
    for (int k = 0; k < 1000 && !seen; k++) begin
      far_lp = (m_row > 240) ? 40 : 440;
      step_cycle(1, 0, far_lp, 40);
      if (m_sr) begin
        seen = 1;
        chk("t5b.score_right", 32'(bus.score_right), 1);
      end else begin
        step_cycle(0, 0, far_lp, 40);
      end
    end
    chk("t5b.seen", 32'(bus.score_right), 1);
    step_cycle(0, 0, 40, 40);
    chk("t5b.dir", 32'(bus.ball_direction), 1);
    chk("t5b.col", 32'(bus.ball_center_col), 320);

    // right miss from a fresh serve
    do_reset();
    serve_and_launch();
    seen = 0;
    for (int k = 0; k < 1000 && !seen; k++) begin
      step_cycle(1, 0, 40, 40);
      if (m_sl) seen = 1;
      else step_cycle(0, 0, 40, 40);
    end
    chk("t5.score_left", 32'(bus.score_left), 1);
    step_cycle(0, 0, 40, 40);
    chk("t5.pulse_drop", 32'(bus.score_left), 0);
    chk("t5.row", 32'(bus.ball_center_row), 240);
    chk("t5.col", 32'(bus.ball_center_col), 320);
    chk("t5.dir", 32'(bus.ball_direction), 3);
    chk("t5.active", 32'(bus.ball_active), 0);
    repeat (3) tick(40, 40);
    chk("t5.idle_row", 32'(bus.ball_center_row), 240);

    // asynchronous reset mid-flight
    serve_and_launch();
    repeat (10) tick(40, 40);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6.row", 32'(bus.ball_center_row), 240);
    chk("t6.col", 32'(bus.ball_center_col), 320);
    chk("t6.dir", 32'(bus.ball_direction), 3);
    chk("t6.active", 32'(bus.ball_active), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) tick(40, 40);
    chk("t6.still_idle", 32'(bus.ball_active), 0);

    // random play with paddles often near the ball
    for (int i = 0; i < 16000; i++) begin
      bit t, s;
      int lp, rp;
      t = ($urandom_range(0, 1) == 1);
      s = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) != 0) lp = m_row + $urandom_range(0, 80) - 40;
      else lp = $urandom_range(0, 479);
      if ($urandom_range(0, 3) != 0) rp = m_row + $urandom_range(0, 80) - 40;
      else rp = $urandom_range(0, 479);
      if (lp < 0) lp = 0;
      if (rp < 0) rp = 0;
      if (lp > 479) lp = 479;
      if (rp > 479) rp = 479;
      step_cycle(t, s, lp, rp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ball_motion_ctrl.md
Name: ball_motion_ctrl

Overview:
Frame-rate sequencer for the ball object. It owns ball position and direction, runs the serve / play / score state machine, bounces the ball off the top and bottom walls and off the paddles, and flags points. Its position outputs drive the ball draw block's center inputs. Position updates only on frame_tick, so a frame is never drawn with a mid-scan position change.

Parameters:
DISP_COLS, 640, visible columns
DISP_ROWS, 480, visible rows
BALL_WIDTH, 6, ball width in pixels (even)
BALL_HEIGHT, 8, ball height in pixels (even)
PADDLE_HEIGHT, 48, paddle height in pixels (even)
LEFT_PADDLE_COL, 16, column of the left paddle's inner face
RIGHT_PADDLE_COL, 624, column of the right paddle's inner face
STEP, 2, pixels moved per axis per frame
SERVE_FRAMES, 60, frames of delay between serve and motion (≥1)
MAX_STEP, 6, speed cap; used only with the optional feature

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
frame_tick  input  1  one-cycle pulse per frame (end of visible area)
serve_req  input  1  level; starts a serve when sampled in IDLE
left_paddle_row  input  12  left paddle center row
right_paddle_row  input  12  right paddle center row
ball_center_row  output  12  ball center row, registered
ball_center_col  output  12  ball center column, registered
ball_direction  output  2  bit1 = right, bit0 = down (00 UP_LEFT, 01 DOWN_LEFT, 10 UP_RIGHT, 11 DOWN_RIGHT)
ball_active  output  1  high in MOVING
paddle_hit  output  1  one-cycle pulse on a paddle bounce
score_left  output  1  one-cycle pulse; left player scored
score_right  output  1  one-cycle pulse; right player scored

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values:
  - state IDLE
  - row DISP_ROWS/2 (240); col DISP_COLS/2 (320)
  - direction 2'b11 (DOWN_RIGHT)
  - ball_active, paddle_hit, score_left, score_right all 0
  - serve counter 0; current step = STEP
- All outputs are registered. An event sampled at cycle N appears at cycle N+1.
- States:
  - IDLE: ball held at center. serve_req=1 → SERVE, counter loaded with SERVE_FRAMES. frame_tick is ignored.
  - SERVE: counter decrements on each frame_tick. A frame_tick with counter==1 → MOVING, so motion starts exactly SERVE_FRAMES ticks after entry. serve_req is ignored.
  - MOVING: one position update per frame_tick (rules below).
  - SCORED: lasts one cycle.
    - Recenters the ball and restores step to STEP.
    - Sets direction toward the player who missed: right missed → DOWN_RIGHT; left missed → DOWN_LEFT.
    - Then → IDLE.
- Arithmetic: all next-position math in 13-bit signed, with no 12-bit wrap. Let h = BALL_HEIGHT/2 and w = BALL_WIDTH/2.
- Vertical motion:
  - Moving down with next row + h ≥ DISP_ROWS−1: row = DISP_ROWS−1−h (475) and bit0 cleared.
  - Moving up with next row − h ≤ 0: row = h (4) and bit0 set.
- Paddle hit:
  - The ball's leading edge crosses a paddle plane on this update:
    - right: current col+w < RIGHT_PADDLE_COL and next col+w ≥ RIGHT_PADDLE_COL;
    - left: current col−w > LEFT_PADDLE_COL and next col−w ≤ LEFT_PADDLE_COL.
  - Row overlap: |row − paddle_row| ≤ PADDLE_HEIGHT/2 + h.
  - Crossing with overlap: col is clamped to the near side of the plane (right: RIGHT_PADDLE_COL−1−w = 620; left: LEFT_PADDLE_COL+1+w = 20), bit1 is flipped, and paddle_hit pulses.
  - Crossing without overlap: the ball passes and continues.
- Miss:
  - Moving right with next col+w ≥ DISP_COLS−1: score_left pulses, → SCORED.
  - Moving left with next col−w ≤ 0: score_right pulses, → SCORED.
- Simultaneous events:
  - A wall bounce and a paddle bounce in the same tick are both applied.
  - A score and a wall bounce in the same tick: the score wins; position is recentered.
- A frame_tick arriving in the same cycle as a state entry is processed by the new state starting the next cycle.
- rst_n asserted in any state returns all registers to their reset values immediately.

Optional Feature:
BALL_SPEEDUP_EN
- Defined: each paddle_hit increments the current step by 1, saturating at MAX_STEP. The step resets to STEP on SCORED and on reset. Both axes use the current step.
- Undefined: step is the constant STEP; MAX_STEP is unused.

Test Plan:
1. Assert rst_n=0, release with no serve, then 10 frame_ticks → row 240, col 320, direction 11, ball_active 0, no pulses.
2. serve_req=1 for one cycle, then 60 frame_ticks → ball_active rises after tick 60. Tick 61 → row 242, col 322.
3. MOVING, DOWN_RIGHT, row 474, frame_tick → row 475, direction 10. Next tick → row 473.
4. MOVING right, col 619, right_paddle_row equal to ball row, frame_tick → col 620, direction bit1=0, paddle_hit high for exactly one cycle. With BALL_SPEEDUP_EN, the next tick moves 3 pixels.
5. MOVING right, right_paddle_row 40, ball row 240, col 634, frame_tick → score_left for one cycle, then row 240, col 320, direction 11, state IDLE, ball_active 0.
6. Mid-MOVING at row 300, col 400, pulse rst_n low between clock edges → outputs at reset values before the next clk edge, and a serve is still required to move.
